// File: rtl/serial_chunk_adder_pkg.sv
// serial_chunk_adder_pkg
// Shared definitions for the digit-serial adder.
// It holds the FSM state encoding and the helper that sizes the chunk counter.
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Chunk counter width. It is at least one bit, so a single-chunk
    // configuration still has a legal counter register.
    function automatic int cnt_width(input int width, input int chunk);
        int n;
        n = width / chunk;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_chunk_adder_if.sv
// serial_chunk_adder_if
// Operand and result bus with valid/ready handshakes on both sides.
//   master : drives A, B, C_in, Sub, In_valid, Out_ready
//   slave  : drives In_ready, Sum, C_out, Overflow, Out_valid
interface serial_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
    logic             Sub;
    logic             In_valid;
    logic             In_ready;
    logic [WIDTH-1:0] Sum;
    logic             C_out;
    logic             Overflow;
    logic             Out_valid;
    logic             Out_ready;

    modport master (
        output A, B, C_in, Sub, In_valid, Out_ready,
        input  In_ready, Sum, C_out, Overflow, Out_valid
    );

    modport slave (
        input  A, B, C_in, Sub, In_valid, Out_ready,
        output In_ready, Sum, C_out, Overflow, Out_valid
    );
endinterface

// File: rtl/chunk_adder.sv
// chunk_adder
// Combinational CHUNK-bit ripple adder built from full_adder cells.
//   a_i, b_i, cin_i : chunk operands and carry-in
//   sum_o           : chunk sum
//   cout_o          : carry out of the chunk MSB
//   cmsb_o          : carry into the chunk MSB, used for signed overflow
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        full_adder u_fa (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .cin_i  (c[i]),
            .sum_o  (sum_o[i]),
            .cout_o (c[i+1])
        );
    end

    assign cout_o = c[CHUNK];
    assign cmsb_o = c[CHUNK-1];
endmodule

// File: rtl/full_adder.sv
// full_adder
// Single-bit full adder cell.
//   a_i, b_i, cin_i : addends and carry-in
//   sum_o, cout_o   : sum bit and carry-out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
// Digit-serial adder/subtractor. It processes CHUNK bits per cycle, starting
// with the LSB chunk, through one shared ripple stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of serial_chunk_adder_if (operands in, result out)
// Subtraction is A + ~B + ~C_in, so C_out=1 means "no borrow".
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_chunk_adder_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(WIDTH, CHUNK);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > WIDTH) begin : g_bad_cfg
        $error("serial_chunk_adder: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // B already inverted for subtract
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout, ch_cmsb;

    assign base = 32'(cnt_q) * 32'(CHUNK);

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a_i    (a_q[base +: CHUNK]),
        .b_i    (b_q[base +: CHUNK]),
        .cin_i  (carry_q),
        .sum_o  (ch_sum),
        .cout_o (ch_cout),
        .cmsb_o (ch_cmsb)
    );

    // In_ready is held low during reset, so that no transfer is implied.
    assign bus.In_ready  = (state_q == IDLE) && !rst;
    assign bus.Out_valid = (state_q == DONE);
    assign bus.Sum       = sum_q;
    assign bus.C_out     = cout_q;
    assign bus.Overflow  = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.In_valid && bus.In_ready) begin
                    a_d     = bus.A;
                    b_d     = bus.Sub ? ~bus.B : bus.B;
                    carry_d = bus.Sub ? ~bus.C_in : bus.C_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: CHUNK] = ch_sum;
                carry_d              = ch_cout;
                if (cnt_q == LAST) begin
                    cout_d  = ch_cout;
                    ovf_d   = ch_cmsb ^ ch_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (bus.Out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
